// File: rtl/mix_lo_ctrl.sv
// Mixer LO sequencer: pairs interpolator samples with fs/4 LO codes and flushes zeros on stop.
// Optional macro MIX_LO_PHASE_OFS_EN adds a phase_ofs input that rotates the LO table lookup.
module mix_lo_ctrl #(
  parameter int DW      = 15,
  parameter int FLUSH_N = 4
) (
  input  logic          clk,
  input  logic          rst,
`ifdef MIX_LO_PHASE_OFS_EN
  input  logic [1:0]    phase_ofs,
`endif
  input  logic          en,
  input  logic          quad,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] data_o,
  output logic [1:0]    lo_o,
  output logic [1:0]    phase_o,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [8:0] FLUSH_LIM = 9'(FLUSH_N);

  state_t        r_state;
  state_t        w_stateNext;
  logic [1:0]    r_phase;
  logic          r_qsel;
  logic [8:0]    r_flushLoaded;
  logic [8:0]    r_flushRetired;
  logic          r_isFlush;
  logic          r_mValid;
  logic [DW-1:0] r_data;
  logic [1:0]    r_lo;
  logic [1:0]    r_phaseO;

  logic          w_free;
  logic          w_accept;
  logic          w_flushLoad;
  logic          w_flushRetire;
  logic [1:0]    w_phaseNext;
  logic [1:0]    w_ofs;
  logic [1:0]    w_loIdx;
  logic [1:0]    w_loCode;

`ifdef MIX_LO_PHASE_OFS_EN
  logic [1:0]    r_ofs;
  assign w_ofs = r_ofs;
`else
  assign w_ofs = 2'd0;
`endif

  assign w_free        = !r_mValid | m_ready;
  assign s_ready       = (r_state == RUN) & w_free;
  assign w_accept      = s_valid & s_ready;
  assign w_flushLoad   = (r_state == DRAIN) & w_free & (r_flushLoaded < FLUSH_LIM);
  assign w_flushRetire = (r_state == DRAIN) & r_mValid & m_ready & r_isFlush;
  assign w_phaseNext   = w_accept ? r_phase + 2'd1 : r_phase;
  assign w_loIdx       = r_phase + w_ofs;

  // Sine table is the cosine table delayed by one phase.
  always_comb begin
    w_loCode = 2'b00;
    if (!r_qsel) begin
      case (w_loIdx)
        2'd0:    w_loCode = 2'b01;
        2'd2:    w_loCode = 2'b10;
        default: w_loCode = 2'b00;
      endcase
    end else begin
      case (w_loIdx)
        2'd1:    w_loCode = 2'b01;
        2'd3:    w_loCode = 2'b10;
        default: w_loCode = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  // Stop is taken only where the unoffset phase lands on 0, so the LO period always completes.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (en) w_stateNext = RUN;
      RUN:     if (!en && (w_phaseNext == 2'd0)) w_stateNext = DRAIN;
      DRAIN:   if (w_flushRetire && (r_flushRetired == FLUSH_LIM - 9'd1)) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase        <= 2'd0;
      r_qsel         <= 1'b0;
      r_flushLoaded  <= 9'd0;
      r_flushRetired <= 9'd0;
`ifdef MIX_LO_PHASE_OFS_EN
      r_ofs          <= 2'd0;
`endif
    end else begin
      r_phase <= (r_state == RUN) ? w_phaseNext : 2'd0;
      if (r_state == IDLE && en) begin
        r_qsel <= quad;
`ifdef MIX_LO_PHASE_OFS_EN
        r_ofs  <= phase_ofs;
`endif
      end
      if (r_state == DRAIN) begin
        if (w_flushLoad)   r_flushLoaded  <= r_flushLoaded + 9'd1;
        if (w_flushRetire) r_flushRetired <= r_flushRetired + 9'd1;
      end else begin
        r_flushLoaded  <= 9'd0;
        r_flushRetired <= 9'd0;
      end
    end
  end

  // Single output stage: holds while stalled, reloads when free or retiring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mValid  <= 1'b0;
      r_data    <= '0;
      r_lo      <= 2'b00;
      r_phaseO  <= 2'd0;
      r_isFlush <= 1'b0;
    end else if (w_accept) begin
      r_mValid  <= 1'b1;
      r_data    <= s_data;
      r_lo      <= w_loCode;
      r_phaseO  <= r_phase;
      r_isFlush <= 1'b0;
    end else if (w_flushLoad) begin
      r_mValid  <= 1'b1;
      r_data    <= '0;
      r_lo      <= 2'b00;
      r_phaseO  <= 2'd0;
      r_isFlush <= 1'b1;
    end else if (m_ready) begin
      r_mValid  <= 1'b0;
    end
  end

  assign m_valid = r_mValid;
  assign data_o  = r_data;
  assign lo_o    = r_lo;
  assign phase_o = r_phaseO;
  assign busy    = (r_state != IDLE) | r_mValid;

endmodule

// File: tb/tb_mix_lo_ctrl.sv
// Directed bench for mix_lo_ctrl: cos/sin streams, stalls, period-boundary stop, flush and reset.
// Define MIX_LO_PHASE_OFS_EN on both files to also exercise the phase offset input.
module tb_mix_lo_ctrl;

  localparam int DW      = 15;
  localparam int FLUSH_N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          quad;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] data_o;
  logic [1:0]    lo_o;
  logic [1:0]    phase_o;
  logic          busy;
`ifdef MIX_LO_PHASE_OFS_EN
  logic [1:0]    phase_ofs;
`endif

  int errors = 0;
  int checks = 0;

  logic [1:0] cosLo [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] ofsLo [4] = '{2'b00, 2'b10, 2'b00, 2'b01};

  mix_lo_ctrl #(.DW(DW), .FLUSH_N(FLUSH_N)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef MIX_LO_PHASE_OFS_EN
    .phase_ofs(phase_ofs),
`endif
    .en      (en),
    .quad    (quad),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .data_o  (data_o),
    .lo_o    (lo_o),
    .phase_o (phase_o),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sv, input logic [DW-1:0] sd);
    s_valid = sv;
    s_data  = sd;
    tick();
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic mv, input logic [DW-1:0] d,
                             input logic [1:0] lo, input logic [1:0] ph);
    checkVal({tag, ".m_valid"}, 32'(m_valid), 32'(mv));
    checkVal({tag, ".data_o"},  32'(data_o),  32'(d));
    checkVal({tag, ".lo_o"},    32'(lo_o),    32'(lo));
    checkVal({tag, ".phase_o"}, 32'(phase_o), 32'(ph));
  endtask

  task automatic resetDut();
    rst     = 1'b1;
    en      = 1'b0;
    quad    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
`ifdef MIX_LO_PHASE_OFS_EN
    phase_ofs = 2'd0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] start");

    // Reset state, then a back-to-back cosine stream.
    resetDut();
    checkOutput("reset", 1'b0, '0, 2'b00, 2'd0);
    checkVal("reset.busy", 32'(busy), 0);
    checkVal("reset.s_ready", 32'(s_ready), 0);
    quad = 1'b0; en = 1'b1; m_ready = 1'b1;
    tick();
    checkVal("cos.s_ready_run", 32'(s_ready), 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 15'(32'h1000 + i));
      checkOutput($sformatf("cos%0d", i), 1'b1, 15'(32'h1000 + i), cosLo[i % 4], 2'(i % 4));
      checkVal($sformatf("cos%0d.s_ready", i), 32'(s_ready), 1);
    end

    // Sine stream with a 3-clock downstream stall on the first beat.
    resetDut();
    quad = 1'b1; en = 1'b1; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    applyStimulus(1'b1, 15'h0100);
    checkOutput("sin.first", 1'b1, 15'h0100, 2'b00, 2'd0);
    checkVal("sin.first.s_ready", 32'(s_ready), 0);
    s_data = 15'h0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("sin.hold%0d", i), 1'b1, 15'h0100, 2'b00, 2'd0);
      checkVal($sformatf("sin.hold%0d.s_ready", i), 32'(s_ready), 0);
    end
    m_ready = 1'b1;
    #1;
    checkVal("sin.release.s_ready", 32'(s_ready), 1);
    tick();
    checkOutput("sin.release", 1'b1, 15'h0101, 2'b01, 2'd1);
    applyStimulus(1'b0, 15'h0000);
    checkVal("sin.retire.m_valid", 32'(m_valid), 0);
    checkVal("sin.retire.busy", 32'(busy), 1);

    // Mid-period stop: en falls at phase 2, period completes, then FLUSH_N zero beats.
    resetDut();
    quad = 1'b0; en = 1'b1; m_ready = 1'b1;
    tick();
    applyStimulus(1'b1, 15'h0200);
    applyStimulus(1'b1, 15'h0201);
    checkOutput("stop.acc1", 1'b1, 15'h0201, 2'b00, 2'd1);
    en = 1'b0;
    applyStimulus(1'b1, 15'h0202);
    checkOutput("stop.acc2", 1'b1, 15'h0202, 2'b10, 2'd2);
    applyStimulus(1'b1, 15'h0203);
    checkOutput("stop.acc3", 1'b1, 15'h0203, 2'b00, 2'd3);
    checkVal("stop.drain.s_ready", 32'(s_ready), 0);
    s_data = 15'h0204;
    for (int i = 0; i < FLUSH_N; i++) begin
      tick();
      checkOutput($sformatf("stop.flush%0d", i), 1'b1, '0, 2'b00, 2'd0);
      checkVal($sformatf("stop.flush%0d.s_ready", i), 32'(s_ready), 0);
    end
    tick();
    checkVal("stop.idle.m_valid", 32'(m_valid), 0);
    checkVal("stop.idle.busy", 32'(busy), 0);
    s_valid = 1'b0;

    // Asynchronous reset in the middle of the flush, then restart at phase 0.
    resetDut();
    quad = 1'b1; en = 1'b1; m_ready = 1'b1;
    tick();
    applyStimulus(1'b1, 15'h0300);
    applyStimulus(1'b1, 15'h0301);
    applyStimulus(1'b1, 15'h0302);
    en = 1'b0;
    applyStimulus(1'b1, 15'h0303);
    checkOutput("rstd.acc3", 1'b1, 15'h0303, 2'b10, 2'd3);
    applyStimulus(1'b0, 15'h0000);
    tick();
    checkOutput("rstd.flush1", 1'b1, '0, 2'b00, 2'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstd.async", 1'b0, '0, 2'b00, 2'd0);
    checkVal("rstd.async.busy", 32'(busy), 0);
    checkVal("rstd.async.s_ready", 32'(s_ready), 0);
    #2 rst = 1'b0;
    quad = 1'b0; en = 1'b1;
    tick();
    applyStimulus(1'b1, 15'h0310);
    checkOutput("rstd.restart", 1'b1, 15'h0310, 2'b01, 2'd0);
    s_valid = 1'b0;

    // en re-raised during the flush, with a downstream stall on the first flush beat.
    resetDut();
    quad = 1'b0; en = 1'b1; m_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 15'(32'h0400 + i));
    en = 1'b0;
    applyStimulus(1'b0, 15'h0000);
    checkVal("retog.drain.m_valid", 32'(m_valid), 0);
    checkVal("retog.drain.busy", 32'(busy), 1);
    checkVal("retog.drain.s_ready", 32'(s_ready), 0);
    en = 1'b1;
    tick();
    checkOutput("retog.flush1", 1'b1, '0, 2'b00, 2'd0);
    m_ready = 1'b0;
    tick();
    checkOutput("retog.stall1", 1'b1, '0, 2'b00, 2'd0);
    tick();
    checkOutput("retog.stall2", 1'b1, '0, 2'b00, 2'd0);
    m_ready = 1'b1;
    for (int i = 2; i <= FLUSH_N; i++) begin
      tick();
      checkOutput($sformatf("retog.flush%0d", i), 1'b1, '0, 2'b00, 2'd0);
      checkVal($sformatf("retog.flush%0d.s_ready", i), 32'(s_ready), 0);
    end
    tick();
    checkVal("retog.idle.m_valid", 32'(m_valid), 0);
    checkVal("retog.idle.busy", 32'(busy), 0);
    checkVal("retog.idle.s_ready", 32'(s_ready), 0);
    tick();
    checkVal("retog.run.s_ready", 32'(s_ready), 1);
    applyStimulus(1'b1, 15'h0410);
    checkOutput("retog.first", 1'b1, 15'h0410, 2'b01, 2'd0);
    s_valid = 1'b0;

`ifdef MIX_LO_PHASE_OFS_EN
    // Offset of 1 rotates the cosine lookup; phase_o stays unoffset.
    resetDut();
    phase_ofs = 2'd1; quad = 1'b0; en = 1'b1; m_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 15'(32'h0500 + i));
      checkOutput($sformatf("ofs%0d", i), 1'b1, 15'(32'h0500 + i), ofsLo[i], 2'(i));
    end
    s_valid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mix_lo_ctrl.md
Name: mix_lo_ctrl

Overview:
- Sequences the mixer: pairs each interpolator sample with the correct 2-bit LO code for fs/4 upconversion.
- Codes are presented to the combinational mixer as a registered data/LO beat.
- Valid/ready stream between the interpolator (upstream) and the delta-sigma modulator input stage (downstream).
- Clean start/stop: output stops only at an LO-period boundary, followed by a zero flush so the modulator settles.

Parameters:
- DW, 15, sample width (matches mixer interp_i).
- FLUSH_N, 4, number of zero beats emitted after stop (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  run request; level-sensitive
- quad  input  1  LO select: 0 = cosine pattern, 1 = sine pattern; sampled on IDLE->RUN only
- s_valid  input  1  upstream sample valid
- s_ready  output  1  upstream ready
- s_data  input  DW  upstream sample (two's complement)
- m_valid  output  1  beat valid to mixer/modulator
- m_ready  input  1  downstream ready
- data_o  output  DW  sample to mixer interp_i
- lo_o  output  2  LO code to mixer: 01 = +x, 10 = -x, 00 = zero; 11 never driven
- phase_o  output  2  phase index of the current output beat
- busy  output  1  high in RUN or DRAIN

Behaviour:
- Reset (async, immediate, any state): state = IDLE; phase = 0; m_valid = 0; data_o = 0; lo_o = 00; phase_o = 0; busy = 0; s_ready = 0.
- LO tables, indexed by phase 0..3:
  - cos: 01, 00, 10, 00
  - sin: 00, 01, 00, 10
- Output register:
  - Single stage.
  - Holds data_o, lo_o, phase_o and m_valid stable while m_valid = 1 and m_ready = 0.
  - Beat retires on m_valid & m_ready.
- s_ready = (state == RUN) & (!m_valid | m_ready). Combinational, so a full-throughput stream runs at 1 beat/clk.
- Accept (s_valid & s_ready), at the next edge:
  - data_o = s_data; lo_o = table[phase]; phase_o = phase; m_valid = 1; phase = phase + 1 mod 4.
  - Latency 1 clk from accept to m_valid.
- States:
  - IDLE:
    - s_ready = 0; phase = 0.
    - en = 1 -> latch quad into qsel, go to RUN.
  - RUN:
    - Accept as above.
    - en = 0 while phase == 0 -> DRAIN.
    - en = 0 while phase != 0 -> keep accepting until phase wraps to 0, then DRAIN. The LO period is always completed; an upstream stall extends RUN.
  - DRAIN:
    - s_ready = 0.
    - Emits FLUSH_N beats with data_o = 0, lo_o = 00, phase_o = 0. Each beat is loaded only when the output register is free or retiring.
    - Counter tracks retired flush beats.
    - When the last flush beat retires -> IDLE. m_valid falls the same edge unless another beat is loaded.
- en is ignored in DRAIN; reasserting en there takes effect only after IDLE is reached.
- Simultaneous accept and en fall on the phase-3 beat: that beat is accepted, phase becomes 0, state goes to DRAIN the same edge.
- busy = (state != IDLE) | m_valid.
- quad changes during RUN/DRAIN have no effect.

Optional Feature:
- Macro: MIX_LO_PHASE_OFS_EN.
- Defined:
  - Adds input port phase_ofs [1:0], sampled with quad on IDLE->RUN.
  - LO lookup index = (phase + ofs) mod 4.
  - phase_o still reports the unoffset phase.
  - Period-boundary stop rule still uses the unoffset phase == 0.
- Undefined: no port; offset is 0.

Test Plan:
- Cos stream: quad = 0, en = 1, m_ready = 1, s_data = 0x1000, 0x1001, 0x1002, 0x1003, 0x1004 back-to-back -> lo_o = 01, 00, 10, 00, 01; data_o echoes each sample 1 clk after accept; s_ready held high.
- Sin stall: quad = 1; m_ready = 0 for 3 clk after first beat -> data_o = first sample and lo_o = 00 held stable, s_ready = 0; m_ready = 1 releases it and the next beat carries lo_o = 01.
- Mid-period stop: en falls after 2 accepts (phase = 2) -> exactly 2 more samples accepted (lo 10, 00), then 4 beats of data_o = 0, lo_o = 00, then IDLE with busy = 0.
- Reset mid-DRAIN: rst pulse after 2nd flush beat -> m_valid = 0, lo_o = 00, data_o = 0 without waiting for clk; after release, en = 1 restarts at phase 0.
- en retoggle in DRAIN: en 0 -> 1 during flush -> all FLUSH_N beats still emitted; RUN entered one clk after IDLE; first LO = table[0].
- MIX_LO_PHASE_OFS_EN defined: phase_ofs = 1, quad = 0 -> lo_o = 00, 10, 00, 01; phase_o = 0, 1, 2, 3.
